// File: rtl/arbitro_fifos.sv
// -----------------------------------------------------------------------------
// arbitro_fifos
//
// Round-robin arbiter that drains N per-lane input FIFOs into one shared
// output channel feeding the downstream FIFO. One lane is granted at a time
// for up to QUANTUM pops, then the grant rotates to the next non-empty lane.
// Downstream flow control: `pausa` stalls popping, `error_full` aborts into
// an ERROR state until it clears.
//
// Optional feature (macro ARB_STATS_EN): adds output `cuenta`, one 16-bit
// saturating pop counter per lane, cleared only by reset.
//
// Parameters:
//   N        number of lanes (>= 2)
//   DATA_W   data width per lane
//   QUANTUM  maximum consecutive pops per grant (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   empty       per-lane FIFO empty flags
//   data_in     per-lane FIFO read data, lane i at [i*DATA_W +: DATA_W]
//   pausa       downstream pause request
//   error_full  downstream overflow error (top priority)
//   pop         one-hot combinational read strobe to the lane FIFOs
//   data_out    registered output data
//   valid_out   data_out valid, two cycles after the pop that produced it
//   grant       index of the currently granted lane
//   ocupado     high while arbitrating or serving
//   err         high while in the error state
//   cuenta      (ARB_STATS_EN only) per-lane 16-bit pop counters
// -----------------------------------------------------------------------------
module arbitro_fifos #(
    parameter int unsigned N       = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned QUANTUM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          empty,
    input  logic [N*DATA_W-1:0]   data_in,
    input  logic                  pausa,
    input  logic                  error_full,
    output logic [N-1:0]          pop,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic [$clog2(N)-1:0]  grant,
    output logic                  ocupado,
    output logic                  err
`ifdef ARB_STATS_EN
    ,
    output logic [N*16-1:0]       cuenta
`endif
);

    localparam int unsigned   GW        = $clog2(N);
    localparam int unsigned   CW        = $clog2(QUANTUM + 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(N - 1);
    localparam logic [CW-1:0] Q_LAST    = CW'(QUANTUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SERVE,
        ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  last_q, last_d;
    logic [CW-1:0]  count_q, count_d;
    logic           pop_any;

    logic [GW-1:0]  next_lane;
    logic           next_found;

    // Read-side pipeline: the FIFO returns data one cycle after pop, and the
    // output register adds one more, giving valid_out two cycles after pop.
    logic           pipe_v;
    logic [GW-1:0]  pipe_lane;

    // Lane index `off` positions after `base`, wrapping modulo N.
    function automatic logic [GW-1:0] lane_after(input logic [GW-1:0] base,
                                                  input int unsigned  off);
        logic [31:0] s;
        s = (32'(base) + off) % N;
        return s[GW-1:0];
    endfunction

    // Round-robin search: last+1, last+2, ... with the last-granted lane
    // itself checked at the very end.
    always_comb begin
        next_found = 1'b0;
        next_lane  = last_q;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!next_found && !empty[lane_after(last_q, k)]) begin
                next_found = 1'b1;
                next_lane  = lane_after(last_q, k);
            end
        end
    end

    // Next-state logic. error_full is checked first everywhere so it wins
    // over pausa and also suppresses pop in the same cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        count_d = count_q;
        pop_any = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (error_full) begin
                    state_d = ERROR;
                end else if (empty != '1) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                if (error_full) begin
                    state_d = ERROR;
                end else if (next_found) begin
                    grant_d = next_lane;
                    last_d  = next_lane;
                    count_d = '0;
                    state_d = SERVE;
                end else begin
                    state_d = IDLE;
                end
            end

            SERVE: begin
                if (error_full) begin
                    state_d = ERROR;
                end else if (!pausa) begin
                    if (!empty[grant_q]) begin
                        pop_any = 1'b1;
                        count_d = count_q + CW'(1);
                        // Quantum exhausted: rotate even if the lane still
                        // holds data; an emptied lane also lands here.
                        if (count_q == Q_LAST) begin
                            state_d = ARB;
                        end
                    end else begin
                        state_d = ARB;
                    end
                end
            end

            ERROR: begin
                if (!error_full) begin
                    state_d = IDLE;
                    // Restart the rotation so lane 0 is favoured next.
                    last_d  = LAST_INIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_INIT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // The lane is latched with the pop so the data is taken from the lane
    // that was actually read, independent of later grant changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v    <= 1'b0;
            pipe_lane <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            pipe_v    <= pop_any;
            pipe_lane <= grant_q;
            valid_out <= pipe_v;
            if (pipe_v) begin
                data_out <= data_in[32'(pipe_lane) * DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (pop_any) begin
            pop = {{(N-1){1'b0}}, 1'b1} << grant_q;
        end
    end

    assign grant   = grant_q;
    assign ocupado = (state_q == ARB) || (state_q == SERVE);
    assign err     = (state_q == ERROR);

`ifdef ARB_STATS_EN
    logic [15:0] stat_q [N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (pop[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        cuenta = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cuenta[i*16 +: 16] = stat_q[i];
        end
    end
`endif

endmodule

// File: doc/arbitro_fifos.md
Name: arbitro_fifos

Overview:
- Round-robin arbiter that drains N input FIFOs into one shared output channel.
- Sits between the per-lane FIFOs and the downstream FIFO.
- Obeys the downstream flow-control signals `pausa` and `error_full`.
- Grants one lane at a time for up to QUANTUM pops, then rotates to the next lane.

Parameters:
N, 4, number of input FIFOs (lanes); N >= 2.
DATA_W, 8, data width per lane.
QUANTUM, 4, maximum consecutive pops per grant; QUANTUM >= 1.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
empty  input  N  per-lane FIFO empty flags.
data_in  input  N*DATA_W  per-lane FIFO read data; lane i occupies bits [i*DATA_W +: DATA_W].
pausa  input  1  downstream pause request from flow control.
error_full  input  1  downstream overflow error from flow control.
pop  output  N  one-hot read strobe to the lane FIFOs.
data_out  output  DATA_W  registered output data.
valid_out  output  1  data_out valid (push to downstream).
grant  output  $clog2(N)  index of the currently granted lane.
ocupado  output  1  high in states ARB and SERVE.
err  output  1  high in state ERROR.

Behaviour:
- Reset (asynchronous): state=IDLE, grant=0, last pointer=N-1, quantum count=0, data_out=0, valid_out=0, err=0, pop=0.
- Lane FIFO read latency is 1 cycle: data_in of lane i is valid in the cycle after pop[i].
- Output path:
  - data_out captures the granted lane's data_in in that cycle.
  - valid_out=1 two cycles after the pop cycle (one per pop).
  - Pops already issued always deliver, even after pausa or error_full.
- pop is combinational: pop[grant] = (state==SERVE) & ~empty[grant] & ~pausa & ~error_full. All other bits are 0. At most one bit is ever high.
- States:
  - IDLE: error_full -> ERROR; else any ~empty -> ARB; else stay.
  - ARB (exactly 1 cycle, no pop):
    - error_full -> ERROR.
    - Select first lane with ~empty, searching last+1, last+2, ... with wrap modulo N. The last-granted lane is considered last.
    - Lane found: grant and last load the index, count=0, -> SERVE.
    - No lane found: -> IDLE, grant unchanged.
  - SERVE:
    - error_full -> ERROR (priority over all else).
    - count increments on each pop.
    - Pop that brings count to QUANTUM -> ARB.
    - empty[grant] with no pop -> ARB.
    - pausa high: no pop, count and grant held, stay SERVE.
  - ERROR: pop=0, err=1. Leave to IDLE when error_full=0. On exit, last=N-1 so the next grant favours lane 0.
- error_full has top priority in every state and suppresses pop in the same cycle.
- Counter width: $clog2(QUANTUM+1) bits. count never exceeds QUANTUM.
- Simultaneous pausa and error_full: error_full wins.
- Lane becoming empty on the same cycle as the QUANTUM-th pop: -> ARB, no extra cycle.
- Reset mid-burst: pop drops immediately. In-flight data is discarded (valid_out forced 0).

Optional Feature:
ARB_STATS_EN
- Defined:
  - Adds output cuenta [N*16-1:0]: per-lane 16-bit saturating counters of pops granted.
  - Counters stick at 16'hFFFF.
  - Cleared by reset only.
  - Counter increments in the same cycle as pop[i].
- Undefined: cuenta port absent; no counter logic.

Test Plan:
1. Assert reset mid-operation with pop active -> pop=0 immediately; valid_out, err, grant, data_out = 0; state IDLE.
2. N=4, QUANTUM=4, only lane 2 holds 3 words (A1, A2, A3) -> 1 ARB cycle; pop[2] high 3 consecutive cycles; valid_out with A1..A3 two cycles after each pop; then ARB -> IDLE, ocupado=0.
3. All 4 lanes hold 8 words -> grant sequence 0,1,2,3,0,1,2,3. Each grant gives exactly 4 pops, with one pop-free ARB cycle between grants; 32 valid_out total, in order per lane.
4. Lane 0 serving, pausa=1 after 2 pops for 5 cycles -> pop=0 in those cycles, grant=0, count held at 2. After release, 2 more pops, then grant=1.
5. error_full=1 during SERVE -> pop=0 in the same cycle; next cycle err=1, state ERROR; in-flight word still appears on valid_out. Release -> IDLE, then ARB grants lane 0 even if last was lane 3.
6. With ARB_STATS_EN, scenario 3 run -> cuenta per lane = 8. A lane forced through 70000 pops reads 16'hFFFF.
